// File: rtl/reg_dump_reader.sv
// Register bank dump reader: walks every bank register through one read port and streams it MSB byte first.
// Optional trailing XOR checksum byte when REG_DUMP_CHECKSUM_EN is defined.
module reg_dump_reader #(
    parameter int NB_REGISTER = 32,
    parameter int NB_ADDR     = 5,
    parameter int NB_BYTE     = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    output logic [NB_ADDR-1:0]     o_r_addr,
    input  logic [NB_REGISTER-1:0] i_r_data,
    output logic [NB_BYTE-1:0]     o_tx_data,
    output logic                   o_tx_valid,
    input  logic                   i_tx_ready,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam int NB_PER_REG = NB_REGISTER / NB_BYTE;
    localparam int NB_IDX     = (NB_PER_REG > 1) ? $clog2(NB_PER_REG) : 1;

    localparam logic [NB_IDX-1:0]  LAST_IDX  = NB_IDX'(NB_PER_REG - 1);
    localparam logic [NB_ADDR-1:0] LAST_ADDR = '1;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] READ     = 3'd1;
    localparam logic [2:0] SEND     = 3'd2;
    localparam logic [2:0] DONE     = 3'd3;
`ifdef REG_DUMP_CHECKSUM_EN
    localparam logic [2:0] SEND_CKS = 3'd4;
`endif

    logic [2:0]             state;
    logic [NB_ADDR-1:0]     r_addr;
    logic [NB_IDX-1:0]      byte_idx;
    logic [NB_REGISTER-1:0] shift_reg;
    logic                   transfer;
    logic [NB_BYTE-1:0]     cur_byte;
`ifdef REG_DUMP_CHECKSUM_EN
    logic [NB_BYTE-1:0]     cks;
`endif

    // The current byte always sits at the top of the shift register; it shifts left on each transfer.
    assign cur_byte = shift_reg[NB_REGISTER-1 -: NB_BYTE];
    assign transfer = o_tx_valid & i_tx_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            r_addr    <= '0;
            byte_idx  <= '0;
            shift_reg <= '0;
`ifdef REG_DUMP_CHECKSUM_EN
            cks       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state  <= READ;
                        r_addr <= '0;
`ifdef REG_DUMP_CHECKSUM_EN
                        cks    <= '0;
`endif
                    end
                end
                READ: begin
                    shift_reg <= i_r_data;
                    byte_idx  <= '0;
                    state     <= SEND;
                end
                SEND: begin
                    if (transfer) begin
                        shift_reg <= shift_reg << NB_BYTE;
`ifdef REG_DUMP_CHECKSUM_EN
                        cks       <= cks ^ cur_byte;
`endif
                        if (byte_idx == LAST_IDX) begin
                            if (r_addr == LAST_ADDR) begin
`ifdef REG_DUMP_CHECKSUM_EN
                                state <= SEND_CKS;
`else
                                state <= DONE;
`endif
                            end else begin
                                r_addr <= r_addr + NB_ADDR'(1);
                                state  <= READ;
                            end
                        end else begin
                            byte_idx <= byte_idx + NB_IDX'(1);
                        end
                    end
                end
`ifdef REG_DUMP_CHECKSUM_EN
                SEND_CKS: begin
                    if (transfer) begin
                        state <= DONE;
                    end
                end
`endif
                DONE: begin
                    r_addr <= '0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        o_tx_data = cur_byte;
`ifdef REG_DUMP_CHECKSUM_EN
        if (state == SEND_CKS) begin
            o_tx_data = cks;
        end
`endif
    end

`ifdef REG_DUMP_CHECKSUM_EN
    assign o_tx_valid = (state == SEND) || (state == SEND_CKS);
`else
    assign o_tx_valid = (state == SEND);
`endif
    assign o_r_addr = r_addr;
    assign o_busy   = (state != IDLE);
    assign o_done   = (state == DONE);

endmodule

// File: tb/tb_reg_dump_reader.sv
// Scoreboard bench for reg_dump_reader: stimulus pushes expected bytes, a monitor pops and compares on each transfer.
module tb_reg_dump_reader;

`ifdef REG_DUMP_CHECKSUM_EN
    localparam int  NBYTES     = 129;
    localparam int  DONE_EDGE  = 161;
    localparam logic [7:0] LAST6 = 8'h08;
`else
    localparam int  NBYTES     = 128;
    localparam int  DONE_EDGE  = 160;
    localparam logic [7:0] LAST6 = 8'h00;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  r_addr;
    logic [31:0] r_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        done;

    logic [31:0] bank [32];
    int          cyc = 0;

    logic [7:0]  exp_q [$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          rx_count = 0;
    int          done_count = 0;
    int          start_edge = 0;
    int          done_edge = -1;
    logic        hold_pending = 1'b0;
    logic [7:0]  held_data = 8'h00;
    logic [7:0]  last_byte = 8'h00;
    logic [7:0]  exp_b;
    int          base_rx;
    int          base_done;

    assign r_data = bank[r_addr];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    reg_dump_reader #(.NB_REGISTER(32), .NB_ADDR(5), .NB_BYTE(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .o_r_addr(r_addr), .i_r_data(r_data),
        .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
        .o_busy(busy), .o_done(done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_dump();
        logic [7:0] x;
        logic [7:0] b;
        x = 8'h00;
        for (int k = 0; k < 32; k++) begin
            for (int j = 3; j >= 0; j--) begin
                b = bank[k][j*8 +: 8];
                exp_q.push_back(b);
                x = x ^ b;
            end
        end
`ifdef REG_DUMP_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        start_edge = cyc + 1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic begin_dump();
        base_rx   = rx_count;
        base_done = done_count;
        push_dump();
        pulse_start();
    endtask

    task automatic finish_dump(input string tag, input bit check_edge);
        for (int i = 0; i < 3000 && done_count == base_done; i++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_done_count"}, 32'(done_count), 32'(base_done + 1));
        check({tag, "_byte_count"}, 32'(rx_count - base_rx), 32'(NBYTES));
        check({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_addr_after"}, 32'(r_addr), 32'd0);
        if (check_edge) check({tag, "_done_edge"}, 32'(done_edge), 32'(DONE_EDGE));
        exp_q.delete();
    endtask

    task automatic wait_bytes(input int n);
        for (int i = 0; i < 3000 && (rx_count - base_rx) < n; i++) @(posedge clk);
        #1;
        check("wait_bytes_reached", 32'((rx_count - base_rx) >= n), 32'd1);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        tx_ready = 1'b1;
        for (int k = 0; k < 32; k++) bank[k] = 32'h0;

        fork
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    hold_pending = 1'b0;
                end else begin
                    if (hold_pending) begin
                        check("hold_valid", 32'(tx_valid), 32'd1);
                        check("hold_data", 32'(tx_data), 32'(held_data));
                        hold_pending = 1'b0;
                    end
                    if (tx_valid && tx_ready) begin
                        if (exp_q.size() == 0) begin
                            n_cmp++;
                            n_err++;
                            $display("FAIL extra_byte: got %02h, none expected", tx_data);
                        end else begin
                            exp_b = exp_q.pop_front();
                            check("stream_byte", 32'(tx_data), 32'(exp_b));
                        end
                        last_byte = tx_data;
                        rx_count++;
                    end else if (tx_valid) begin
                        hold_pending = 1'b1;
                        held_data    = tx_data;
                    end
                    if (done) begin
                        done_count++;
                        done_edge = cyc - start_edge;
                    end
                end
            end
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_addr", 32'(r_addr), 32'd0);
        check("rst_data", 32'(tx_data), 32'd0);
        check("rst_valid", 32'(tx_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;

        // Plain ramp dump, ready held high
        for (int k = 0; k < 32; k++) bank[k] = k * 32'h01010101;
        begin_dump();
        check("t2_busy", 32'(busy), 32'd1);
        finish_dump("t2", 1'b1);

        // Backpressure: stall at byte 6, then toggle ready every cycle
        begin_dump();
        wait_bytes(6);
        tx_ready = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        for (int i = 0; i < 2000 && done_count == base_done; i++) begin
            tx_ready = ~tx_ready;
            @(posedge clk);
            #1;
        end
        tx_ready = 1'b1;
        finish_dump("t3", 1'b0);

        // Start while busy is ignored
        begin_dump();
        wait_bytes(40);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        finish_dump("t4", 1'b1);

        // Mid-dump reset, then a clean restart
        begin_dump();
        wait_bytes(37);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 32'(tx_valid), 32'd0);
        check("t5_rst_data", 32'(tx_data), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_addr", 32'(r_addr), 32'd0);
        check("t5_rst_done", 32'(done), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("t5_no_abort_done", 32'(done_count), 32'(base_done));
        bank[0] = 32'hDEADBEEF;
        begin_dump();
        check("t5_restart_addr", 32'(r_addr), 32'd0);
        @(posedge clk); #1;
        check("t5_first_valid", 32'(tx_valid), 32'd1);
        check("t5_first_byte", 32'(tx_data), 32'hDE);
        finish_dump("t5", 1'b1);

        // Checksum pattern
        for (int k = 0; k < 32; k++) bank[k] = 32'h0;
        bank[1] = 32'h12345678;
        begin_dump();
        finish_dump("t6", 1'b1);
        check("t6_last_byte", 32'(last_byte), 32'(LAST6));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
